wave_capture_buffer: RTL and testbench
======================================

Name: wave_capture_buffer

Overview:
- Sits directly downstream of music_player and consumes its mixed sample stream: new_sample_in driven by sample_out, new_sample_ready by new_sample_generated.
- Waits for a rising zero crossing, then captures a fixed-length window of samples into one half of an external ping-pong display RAM.
- After the window is full, waits for the wave display to go idle, then swaps halves.
- Produces the RAM write port and the read_index that the wave display uses to select its half.

Parameters:
- SAMPLE_WIDTH, 16, width of incoming signed sample.
- DEPTH_LOG2, 8, log2 of samples captured per window (default 256).
- OUT_WIDTH, 8, width of sample written to RAM; must be less than or equal to SAMPLE_WIDTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  SAMPLE_WIDTH  signed two's-complement audio sample.
- wave_display_idle  input  1  high while the display is not reading the RAM (blanking).
- write_address  output  DEPTH_LOG2+1  RAM write address, {write half, sample index}.
- write_enable  output  1  one-cycle RAM write strobe.
- write_sample  output  OUT_WIDTH  offset-binary sample to store.
- read_index  output  1  half of the RAM the display must read; write half is ~read_index.
- capture_state  output  2  current FSM state: 0=ARMED, 1=ACTIVE, 2=WAIT.

Behaviour:
- Single clock domain. Synchronous active-high reset. All outputs are registered.
- Reset values:
  - state=ARMED, count=0, prev_sample=0, read_index=0.
  - write_enable=0, write_address=0, write_sample=0, capture_state=0.
- prev_sample:
  - Loads new_sample_in on every new_sample_ready, in every state.
  - Holds otherwise.
- Trigger: new_sample_ready AND prev_sample MSB=1 AND new_sample_in MSB=1'b0 (negative to zero-or-positive).
- Sample conversion: write_sample = new_sample_in[SAMPLE_WIDTH-1 -: OUT_WIDTH] with the top bit inverted (two's complement to offset binary).
  - 16'h8000 -> 8'h00.
  - 16'h0000 -> 8'h80.
  - 16'h7FFF -> 8'hFF.
- State ARMED:
  - On trigger: the triggering sample is written at index 0, count becomes 1, go to ACTIVE.
  - A non-triggering strobe writes nothing.
- State ACTIVE:
  - Each new_sample_ready writes the sample at index count, then count increments.
  - When the write uses index 2^DEPTH_LOG2-1, count wraps to 0 and the state goes to WAIT.
  - Trigger condition is ignored while in ACTIVE.
- State WAIT:
  - new_sample_ready produces no write; prev_sample still updates.
  - When wave_display_idle=1: read_index toggles, go to ARMED.
  - If wave_display_idle is already high on WAIT entry, the swap happens on the next clock.
- Write timing:
  - A write caused by a strobe at cycle N appears at cycle N+1: write_enable=1 for exactly one cycle, with write_address={~read_index, index} and write_sample.
  - write_address and write_sample hold their last values when write_enable=0.
- read_index only changes on the WAIT->ARMED transition, so the display half never changes mid-window.
- The captured half only becomes readable after the swap.
- Simultaneous events:
  - In the cycle of a WAIT->ARMED swap, a coincident new_sample_ready is not evaluated for trigger; it only updates prev_sample.
  - A trigger in the cycle immediately after the swap writes to the new half (~new read_index).
- Back-to-back strobes on consecutive cycles must be handled: one write per strobe, none dropped.
- Reset mid-operation: the capture is abandoned, the state returns to ARMED, and read_index returns to 0. Partially written RAM contents are left as-is.

Test Plan:
- Reset, with DEPTH_LOG2=3 -> all outputs 0, capture_state=0, no write_enable for 20 cycles of zero-valued strobes.
- Strobes FFF0, FFF8, 0004, then 7 more positive samples -> no write for FFF0/FFF8. Write at {1,000} with sample 0x80 one cycle after the 0004 strobe. Eight writes total at addresses 8..15, then capture_state=2.
- In WAIT with wave_display_idle=0, send 5 more strobes -> no write_enable, read_index stays 0. Raise idle -> read_index=1 next cycle, capture_state=0.
- Second crossing after the swap -> writes go to addresses 0..7. Sample 16'h8000 stores 0x00, 16'h7FFF stores 0xFF.
- Strobes on consecutive cycles during ACTIVE -> one write per cycle with contiguous addresses, none dropped.
- Assert reset after 3 writes of a window -> next cycle capture_state=0, read_index=0. A new crossing restarts at index 0.

Source files
------------

// File: rtl/wave_capture_buffer.sv
// rtl/wave_capture_buffer.sv - zero-crossing triggered capture into a ping-pong display RAM
module wave_capture_buffer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH_LOG2   = 8,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  output logic [DEPTH_LOG2:0]     write_address,
  output logic                    write_enable,
  output logic [OUT_WIDTH-1:0]    write_sample,
  output logic                    read_index,
  output logic [1:0]              capture_state
);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  // Flipping the top bit turns two's complement into offset binary for the display.
  localparam logic [OUT_WIDTH-1:0] MSB_FLIP = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   count;
  logic [SAMPLE_WIDTH-1:0] prev_sample;
  logic                    trigger;
  logic [OUT_WIDTH-1:0]    converted;

  // Rising zero crossing: previous sample negative, current one zero or positive.
  assign trigger   = new_sample_ready && prev_sample[SAMPLE_WIDTH-1] && !new_sample_in[SAMPLE_WIDTH-1];
  assign converted = new_sample_in[SAMPLE_WIDTH-1 -: OUT_WIDTH] ^ MSB_FLIP;

  // The state register is itself the registered state output.
  assign capture_state = state;

  // Capture FSM: arm on a crossing, fill one half, then swap halves once the display is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_ARMED;
      count         <= '0;
      prev_sample   <= '0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      write_enable <= 1'b0;
      if (new_sample_ready) begin
        prev_sample <= new_sample_in;
      end
      case (state)
        S_ARMED: begin
          if (trigger) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, {DEPTH_LOG2{1'b0}}};
            write_sample  <= converted;
            count         <= DEPTH_LOG2'(1);
            state         <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= converted;
            count         <= count + 1'b1;
            if (&count) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Strobes here only refresh prev_sample; the window is complete.
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= S_ARMED;
          end
        end
        default: begin
          state <= S_ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_buffer.sv
// tb/tb_wave_capture_buffer.sv - directed self-checking bench for wave_capture_buffer
module tb_wave_capture_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [3:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  logic [1:0]  capture_state;

  int tests  = 0;
  int failed = 0;

  logic [15:0] b2b_in  [8];
  logic [7:0]  b2b_exp [8];

  wave_capture_buffer #(
    .SAMPLE_WIDTH(16),
    .DEPTH_LOG2  (3),
    .OUT_WIDTH   (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .wave_display_idle(wave_display_idle),
    .write_address    (write_address),
    .write_enable     (write_enable),
    .write_sample     (write_sample),
    .read_index       (read_index),
    .capture_state    (capture_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One isolated strobe; checks the write one cycle later and that the pulse lasts one cycle.
  task automatic send(input string tag, input logic [15:0] v, input logic exp_we,
                      input logic [3:0] exp_addr, input logic [7:0] exp_sample);
    @(negedge clk);
    new_sample_ready = 1'b1;
    new_sample_in    = v;
    @(negedge clk);
    new_sample_ready = 1'b0;
    check({tag, "_we"}, 32'(write_enable), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_addr"}, 32'(write_address), 32'(exp_addr));
      check({tag, "_data"}, 32'(write_sample), 32'(exp_sample));
    end
    @(negedge clk);
    check({tag, "_we_drop"}, 32'(write_enable), 32'd0);
  endtask

  initial begin
    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = 16'h0000;
    wave_display_idle = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we",    32'(write_enable),  32'd0);
    check("rst_addr",  32'(write_address), 32'd0);
    check("rst_data",  32'(write_sample),  32'd0);
    check("rst_ri",    32'(read_index),    32'd0);
    check("rst_state", 32'(capture_state), 32'd0);
    reset = 1'b0;

    // Twenty back-to-back zero strobes never form a crossing.
    new_sample_ready = 1'b1;
    new_sample_in    = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("zero_we", 32'(write_enable), 32'd0);
    end
    new_sample_ready = 1'b0;

    // First crossing into half 1 (read_index=0).
    send("neg0", 16'hFFF0, 1'b0, 4'd0, 8'h00);
    send("neg1", 16'hFFF8, 1'b0, 4'd0, 8'h00);
    send("trig", 16'h0004, 1'b1, 4'd8, 8'h80);
    check("trig_state", 32'(capture_state), 32'd1);
    send("w1", 16'h1000, 1'b1, 4'd9,  8'h90);
    send("w2", 16'h2000, 1'b1, 4'd10, 8'hA0);
    send("w3", 16'h3000, 1'b1, 4'd11, 8'hB0);
    send("w4", 16'h4000, 1'b1, 4'd12, 8'hC0);
    send("w5", 16'h5000, 1'b1, 4'd13, 8'hD0);
    send("w6", 16'h6000, 1'b1, 4'd14, 8'hE0);
    send("w7", 16'h7000, 1'b1, 4'd15, 8'hF0);
    check("full_state", 32'(capture_state), 32'd2);

    // WAIT with display busy: crossings are ignored and no swap happens.
    send("wait0", 16'h0001, 1'b0, 4'd0, 8'h00);
    send("wait1", 16'hFFFF, 1'b0, 4'd0, 8'h00);
    send("wait2", 16'h0001, 1'b0, 4'd0, 8'h00);
    send("wait3", 16'hFFFF, 1'b0, 4'd0, 8'h00);
    send("wait4", 16'h8000, 1'b0, 4'd0, 8'h00);
    check("wait_ri",    32'(read_index),    32'd0);
    check("wait_state", 32'(capture_state), 32'd2);
    @(negedge clk);
    wave_display_idle = 1'b1;
    @(negedge clk);
    wave_display_idle = 1'b0;
    check("swap1_ri",    32'(read_index),    32'd1);
    check("swap1_state", 32'(capture_state), 32'd0);

    // Second window goes to half 0; extreme samples check the conversion.
    send("t2",  16'h0000, 1'b1, 4'd0, 8'h80);
    send("min", 16'h8000, 1'b1, 4'd1, 8'h00);
    send("max", 16'h7FFF, 1'b1, 4'd2, 8'hFF);
    send("s3",  16'h1234, 1'b1, 4'd3, 8'h92);
    send("s4",  16'hC000, 1'b1, 4'd4, 8'h40);
    send("s5",  16'h4000, 1'b1, 4'd5, 8'hC0);
    send("s6",  16'hFF00, 1'b1, 4'd6, 8'h7F);
    send("s7",  16'h0100, 1'b1, 4'd7, 8'h81);
    check("full2_state", 32'(capture_state), 32'd2);

    // Swap with a coincident negative strobe, then a crossing on the very next strobe,
    // then the rest of the window on consecutive cycles.
    @(negedge clk);
    wave_display_idle = 1'b1;
    new_sample_ready  = 1'b1;
    new_sample_in     = 16'h8000;
    @(negedge clk);
    wave_display_idle = 1'b0;
    check("swap2_ri",    32'(read_index),    32'd0);
    check("swap2_state", 32'(capture_state), 32'd0);
    check("swap2_we",    32'(write_enable),  32'd0);
    b2b_in  = '{16'h0010, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'hFE00};
    b2b_exp = '{8'h80,    8'h82,    8'h83,    8'h84,    8'h85,    8'h86,    8'h87,    8'h7E};
    new_sample_in = b2b_in[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_we",   32'(write_enable),  32'd1);
      check("b2b_addr", 32'(write_address), 32'(8 + i));
      check("b2b_data", 32'(write_sample),  32'(b2b_exp[i]));
      if (i < 7) new_sample_in = b2b_in[i + 1];
      else       new_sample_ready = 1'b0;
    end
    check("b2b_state", 32'(capture_state), 32'd2);

    // Swap back to read_index=1, start a window, then abandon it with reset.
    @(negedge clk);
    wave_display_idle = 1'b1;
    @(negedge clk);
    wave_display_idle = 1'b0;
    check("swap3_ri", 32'(read_index), 32'd1);
    send("p0", 16'h0005, 1'b1, 4'd0, 8'h80);
    send("p1", 16'h0100, 1'b1, 4'd1, 8'h81);
    send("p2", 16'h0200, 1'b1, 4'd2, 8'h82);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_state", 32'(capture_state), 32'd0);
    check("mid_rst_ri",    32'(read_index),    32'd0);
    check("mid_rst_we",    32'(write_enable),  32'd0);
    check("mid_rst_addr",  32'(write_address), 32'd0);

    // A fresh crossing restarts at index 0 of half 1.
    send("r_neg",  16'h8000, 1'b0, 4'd0, 8'h00);
    send("r_trig", 16'h0001, 1'b1, 4'd8, 8'h80);
    check("r_state", 32'(capture_state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
